// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial word shifter with a one-entry holding register
// Optional feature macro: SERIALIZER_LSB_FIRST_EN (LSB-first bit order; default is MSB first).
module bit_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIALIZER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;
  logic                w_load;
  logic                w_advance;
  logic                w_head;
  logic [DATA_W-1:0]   w_shift_adv;

  // A word can only enter while the holding slot is empty, so an unload
  // (which needs the slot full) can never coincide with an acceptance.
  assign w_accept = in_valid && !r_hold_full;

  // Bit currently on the wire and the shifter contents after one advance.
  assign w_head      = LSB_FIRST ? r_shift[0] : r_shift[DATA_W-1];
  assign w_shift_adv = LSB_FIRST ? {1'b0, r_shift[DATA_W-1:1]}
                                 : {r_shift[DATA_W-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and shifter control; bit_en only matters once a word is loaded.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (r_cnt != LAST_BIT) begin
            w_advance = 1'b1;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register: filled on acceptance, emptied when the shifter takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= data_in;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Shift register and bit counter; both freeze when bit_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= r_hold;
      r_cnt   <= '0;
    end else if (w_advance) begin
      r_shift <= w_shift_adv;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = !r_hold_full;
  assign dout_valid  = (r_state == SHIFT);
  assign dout        = dout_valid && w_head;
  assign frame_start = dout_valid && (r_cnt == '0);
  assign busy        = dout_valid || r_hold_full;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 data_in  input  DATA_W  parallel word to serialize.
REQ-005 in_valid  input  1  data_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 bit_en  input  1  bit-advance strobe; tie to 1 for one bit per clk.
REQ-008 dout  output  1  serial bit stream, feeds downstream sequence detector din.
REQ-009 dout_valid  output  1  dout carries a word bit.
REQ-010 frame_start  output  1  high while dout carries bit 0 of a word.
REQ-011 busy  output  1  high when shifter or holding register is occupied.

Function
REQ-012 Storage SHALL be a holding register (1 entry, flag hold_full) plus a DATA_W-bit shift register with bit counter of width clog2(DATA_W).
REQ-013 in_ready SHALL equal !hold_full; a word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-014 FSM SHALL have two states: IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-015 IDLE: if hold_full, the next edge SHALL move the holding word into the shifter, clear hold_full, zero the counter, and enter SHIFT.
REQ-016 Latency: a word accepted at edge N SHALL present its first bit on dout with dout_valid=1 immediately after edge N+1.
REQ-017 SHIFT: on an edge with bit_en=1 and counter < DATA_W-1, the shifter SHALL advance one bit and the counter SHALL increment; with bit_en=0, dout SHALL hold.
REQ-018 SHIFT: on an edge with bit_en=1 and counter = DATA_W-1, if hold_full, the holding word SHALL load with the counter zeroed, remaining in SHIFT with no idle cycle; otherwise, the FSM SHALL return to IDLE.
REQ-019 A holding-register unload and a new acceptance SHALL never coincide; in_ready SHALL rise the cycle after unload.
REQ-020 bit_en SHALL be ignored in IDLE.
REQ-021 dout_valid SHALL be 1 exactly in SHIFT; dout and frame_start SHALL be 0 whenever dout_valid=0.
REQ-022 frame_start SHALL be 1 when in SHIFT with counter = 0.
REQ-023 busy SHALL equal (state == SHIFT) || hold_full.
REQ-024 Default bit order SHALL be MSB first (data_in[DATA_W-1] first).
REQ-025 data_in SHALL be ignored when not accepted; words SHALL never be dropped or duplicated.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, hold_full=0, counter=0, shift register=0.
REQ-027 Reset values: in_ready=1, dout=0, dout_valid=0, frame_start=0, busy=0.
REQ-028 Reset mid-word SHALL discard the partial word and any held word; after release, the first accepted word SHALL start cleanly per REQ-016.

Configuration
REQ-029 Macro SERIALIZER_LSB_FIRST_EN: when defined, bit order SHALL be LSB first (data_in[0] first); when undefined, MSB first per REQ-024; all timing SHALL be identical.

Verification
REQ-030 DATA_W=8, bit_en=1, single word 0xD0 accepted at edge N -> dout=1,1,0,1,0,0,0,0 after edges N+1..N+8, frame_start only on first bit, dout_valid=0 after edge N+9.
REQ-031 in_valid held with words 0xDD,0xDD,0xDD -> 24 contiguous dout_valid cycles with no gap, frame_start every 8 cycles, in_ready low while hold_full.
REQ-032 bit_en pulsing 1 cycle in 4, word 0xA5 -> each bit held 4 cycles, total 32 valid cycles, bit sequence 1,0,1,0,0,1,0,1.
REQ-033 reset asserted after 3 bits of 0xFF with a second word held -> same cycle dout_valid=0, busy=0, in_ready=1; a post-release word 0x0D produces 0,0,0,0,1,1,0,1.
REQ-034 SERIALIZER_LSB_FIRST_EN defined, word 0x0B -> dout=1,1,0,1,0,0,0,0.
REQ-035 bit_en=0 throughout SHIFT with word 0x80 -> dout stays 1, dout_valid stays 1, counter frozen, second word accepted into holding register then in_ready=0.
